// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module      : interrupt_controller_if
// Description : Bus bundle between interrupt sources/CPU and the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if #(
    parameter int NUM_CH = 8
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] irq_in;
    logic              mask_we;
    logic [NUM_CH-1:0] mask_din;
    logic              int_set;
    logic              int_clr;
    logic              int_ack;
    logic              isr_done;
    logic              int_req;
    logic [ID_W-1:0]   int_id;
    logic              int_en;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] pending;

    modport master (
        output irq_in, mask_we, mask_din, int_set, int_clr, int_ack, isr_done,
        input  int_req, int_id, int_en, mask, pending
    );

    modport slave (
        input  irq_in, mask_we, mask_din, int_set, int_clr, int_ack, isr_done,
        output int_req, int_id, int_en, mask, pending
    );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritised edge/level interrupt controller with REQ/ACK/DONE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int                 NUM_CH    = 8,
    parameter logic [NUM_CH-1:0]  EDGE_MASK = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    interrupt_controller_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_mask;
    logic              r_int_en;
    logic              r_int_req;
    logic [ID_W-1:0]   r_id;

    logic [NUM_CH-1:0] w_pending_nxt;
    logic [NUM_CH-1:0] w_mask_nxt;
    logic [NUM_CH-1:0] w_eligible;
    logic              w_int_en_nxt;
    logic              w_accept;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_id_nxt;

    assign w_accept   = (r_state == S_REQ) && bus.int_ack;
    assign w_mask_nxt = bus.mask_we ? bus.mask_din : r_mask;
    assign w_eligible = r_pending & r_mask;

    // Acceptance clears the global enable even against a simultaneous set.
    always_comb begin
        w_int_en_nxt = r_int_en;
        if (w_accept)
            w_int_en_nxt = 1'b0;
        else if (bus.int_set)
            w_int_en_nxt = 1'b1;
        else if (bus.int_clr)
            w_int_en_nxt = 1'b0;
    end

    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (EDGE_MASK[i])
                w_pending_nxt[i] = (bus.irq_in[i] & ~r_prev[i]) |
                                   (r_pending[i] & ~(w_accept && (r_id == ID_W'(i))));
            else
                w_pending_nxt[i] = bus.irq_in[i];
        end
    end

    // Scan downwards so the lowest eligible index is the last to be written.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_eligible[i])
                w_winner = ID_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        unique case (r_state)
            S_IDLE: begin
                if (r_int_en && (|w_eligible)) begin
                    w_state_nxt = S_REQ;
                    w_id_nxt    = w_winner;
                end
            end
            S_REQ: begin
                // Withdraw looks at next-edge values so the request drops together with its cause.
                if (bus.int_ack)
                    w_state_nxt = S_SERVICE;
                else if (!w_int_en_nxt || !(w_pending_nxt[r_id] && w_mask_nxt[r_id]))
                    w_state_nxt = S_IDLE;
            end
            S_SERVICE: begin
                if (bus.isr_done)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_int_en  <= 1'b0;
            r_int_req <= 1'b0;
            r_id      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= bus.irq_in;
            r_pending <= w_pending_nxt;
            r_mask    <= w_mask_nxt;
            r_int_en  <= w_int_en_nxt;
            r_int_req <= (w_state_nxt == S_REQ);
            r_id      <= w_id_nxt;
        end
    end

    assign bus.int_req = r_int_req;
    assign bus.int_id  = r_id;
    assign bus.int_en  = r_int_en;
    assign bus.mask    = r_mask;
    assign bus.pending = r_pending;

endmodule

`default_nettype wire

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of interrupt channels (legal range 2..32).
REQ-002 Parameter EDGE_MASK, NUM_CH bits, default all ones; bit i = 1 makes channel i edge-triggered, bit i = 0 makes it level-triggered.
REQ-003 Derived constant ID_W = clog2(NUM_CH), the width of the channel index.
REQ-004 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 IRQ_IN  in  NUM_CH  interrupt sources, synchronous to CLK.
REQ-007 MASK_WE  in  1  write strobe for the mask register.
REQ-008 MASK_DIN  in  NUM_CH  mask write data; 1 = channel enabled.
REQ-009 INT_SET  in  1  set global interrupt enable.
REQ-010 INT_CLR  in  1  clear global interrupt enable.
REQ-011 INT_ACK  in  1  CPU accepts the presented interrupt.
REQ-012 ISR_DONE  in  1  CPU finished the service routine.
REQ-013 INT_REQ  out  1  interrupt request to the CPU.
REQ-014 INT_ID  out  ID_W  index of the requested channel.
REQ-015 INT_EN  out  1  global enable flag.
REQ-016 MASK  out  NUM_CH  current mask register.
REQ-017 PENDING  out  NUM_CH  current pending register.

Function
REQ-018 INT_EN: INT_SET=1 sets it; else INT_CLR=1 clears it; when both are asserted in one cycle, SET wins.
REQ-019 MASK: loaded from MASK_DIN on the cycle MASK_WE=1; otherwise held.
REQ-020 Edge channel: each cycle, IRQ_IN is registered into prev; a rising edge (IRQ_IN[i]=1 and prev[i]=0) sets PENDING[i] on the next edge.
REQ-021 Edge channel: PENDING[i] is cleared only by an accepted INT_ACK for channel i.
REQ-022 Edge channel: if a new edge and the ACK-clear land in the same cycle, the set wins and PENDING[i] remains 1.
REQ-023 Level channel: PENDING[i] follows IRQ_IN[i] with one cycle of latency, and INT_ACK does not clear it.
REQ-024 Eligible vector = PENDING & MASK; masking a channel does not clear its PENDING bit.
REQ-025 Priority: the lowest eligible index wins.
REQ-026 State machine has three states: IDLE, REQ, SERVICE.
REQ-027 IDLE to REQ: when INT_EN=1 and eligible is non-zero, the next state is REQ and INT_ID latches the winning index.
REQ-028 In REQ, INT_REQ=1 and INT_ID is held stable, even if a higher-priority channel becomes eligible.
REQ-029 REQ to SERVICE on INT_ACK=1; in the same edge, INT_EN is cleared (this overrides INT_SET in that cycle) and edge PENDING[INT_ID] is cleared.
REQ-030 REQ to IDLE (withdraw) when INT_EN goes 0, or when PENDING[INT_ID] & MASK[INT_ID] goes 0, without an ACK; INT_REQ then drops on the next edge.
REQ-031 SERVICE to IDLE on ISR_DONE=1; SERVICE ignores all new eligibility.
REQ-032 INT_ACK outside REQ and ISR_DONE outside SERVICE are ignored.
REQ-033 INT_REQ is 1 only in REQ and is registered (glitch-free).
REQ-034 Request latency: an edge on IRQ_IN at cycle t, with the channel enabled and INT_EN=1, gives INT_REQ=1 at cycle t+2.

Reset
REQ-035 While RST=1: INT_EN=0, MASK=0, PENDING=0, prev=0, state=IDLE, INT_REQ=0, INT_ID=0.
REQ-036 Reset mid-REQ or mid-SERVICE aborts immediately and all state is lost.
REQ-037 An edge-mode IRQ_IN that is already high at reset release counts as a rising edge.

Verification
REQ-038 Reset; MASK=0xFF, INT_SET; pulse IRQ_IN[3] at t -> INT_REQ=1 and INT_ID=3 at t+2; ACK -> INT_EN=0, PENDING[3]=0, state SERVICE.
REQ-039 Edges on channels 5 and 2 in the same cycle -> INT_ID=2; after ACK, ISR_DONE and INT_SET -> INT_ID=5.
REQ-040 Channel 1 level, IRQ_IN[1] held high -> PENDING[1] stays 1 after ACK; it re-requests after ISR_DONE and INT_SET.
REQ-041 INT_CLR asserted while in REQ -> INT_REQ=0 next cycle, state IDLE, PENDING unchanged; INT_SET and INT_CLR together -> INT_EN=1.
REQ-042 MASK=0x00 with pending edge on channel 0 -> no request; write MASK=0x01 -> INT_REQ two cycles later.
REQ-043 New edge on channel 4 in its ACK cycle -> PENDING[4]=1 after ACK; assert RST during SERVICE -> all outputs at reset values.
